// File: rtl/basic_adders_pkg.sv
// basic_adders_pkg: shared FSM state encoding for the basic adder/subtractor family
package basic_adders_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor: 1-bit combinational full subtractor cell, d = a - b - bin
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // difference bit and borrow into the next position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b - bin using one shared full-subtractor cell
module serial_subtractor
    import basic_adders_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             br_n;

    full_subtractor u_fs (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (d),
        .bout (br_n)
    );

    // FSM, operand/result shifters and borrow flop; diff/bout only change when a run completes
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_n;
                    res <= {d, res[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff  <= {d, res[WIDTH-1:1]};
                        bout  <= br_n;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        br    <= bin;
                        res   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and exhaustive scoreboard checks of serial_subtractor at WIDTH=4
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       bin = 1'b0;
    logic       busy;
    logic       done;
    logic [3:0] diff;
    logic       bout;

    int errors = 0;
    int checks = 0;
    logic [4:0] q[$];
    logic [4:0] held = '0;

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] model(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
        return {1'b0, ta} - {1'b0, tb} - {4'b0, tbin};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
        @(negedge clk);
        a = ta;
        b = tb;
        bin = tbin;
        start = 1'b1;
        q.push_back(model(ta, tb, tbin));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_done(input string tag, input int exp_busy);
        int nb;
        bit got;
        nb = 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) nb++;
                chk({tag, "_hold"}, {bout, diff}, held);
                @(negedge clk);
            end
        end
        chk({tag, "_done_seen"}, got, 1);
        if (got) begin
            held = q.pop_front();
            chk({tag, "_result"}, {bout, diff}, held);
            chk({tag, "_busy_cycles"}, nb, exp_busy);
            @(negedge clk);
            chk({tag, "_done_pulse"}, done, 0);
            chk({tag, "_after"}, {bout, diff}, held);
        end
    endtask

    task automatic no_done(input string tag, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk({tag, "_no_done"}, cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {busy, done, bout, diff}, 7'd0);

        go(4'b0111, 4'b0011, 1'b0);
        expect_done("t1", 4);
        go(4'b0011, 4'b0111, 1'b0);
        expect_done("t2", 4);
        go(4'b1111, 4'b1111, 1'b1);
        expect_done("t3a", 4);
        go(4'b0000, 4'b0000, 1'b0);
        expect_done("t3b", 4);
        go(4'b0101, 4'b0101, 1'b0);
        expect_done("a_eq_b", 4);

        go(4'b1000, 4'b0110, 1'b0);
        @(negedge clk);
        a = 4'b0001;
        b = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_done("t4", 2);
        no_done("t4", 8);

        go(4'b1100, 4'b1001, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(q.pop_back());
        held = '0;
        chk("t5_abort", {busy, done, bout, diff}, 7'd0);
        no_done("t5", 8);
        go(4'b1100, 4'b1001, 1'b0);
        expect_done("t5_rerun", 4);

        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        held = '0;
        chk("rst_wins", {busy, done, bout, diff}, 7'd0);
        @(negedge clk);
        chk("rst_wins_idle", busy, 0);

        @(negedge clk);
        a = 4'b0101;
        b = 4'b0010;
        bin = 1'b0;
        start = 1'b1;
        q.push_back(model(4'b0101, 4'b0010, 1'b0));
        @(negedge clk);
        a = 4'b0010;
        b = 4'b0101;
        q.push_back(model(4'b0010, 4'b0101, 1'b0));
        expect_done("b2b1", 4);
        start = 1'b0;
        expect_done("b2b2", 4);
        no_done("b2b", 6);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            go(v[8:5], v[4:1], v[0]);
            expect_done("exh", 4);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
